// File: rtl/pause_pkg.sv
// pause_pkg: shared definitions for the pause gate and its helpers.
//   state_t        : pause gate FSM states (RUN / DRAIN / HELD).
//   DRAIN_MS       : default drain window in milliseconds before a forced hold.
//   HELD_FRAMES_W  : width of the held-frame counter.
package pause_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HELD  = 2'd2
    } state_t;

    localparam int DRAIN_MS      = 20;
    localparam int HELD_FRAMES_W = 16;

endpackage

// File: rtl/edge_rise.sv
// edge_rise: 1-bit registered rising-edge detector.
//   clk     in  clock
//   reset_n in  asynchronous active-low reset (history register clears to 0)
//   d       in  level input, synchronous to clk
//   rise    out high for the cycle in which d is 1 and was 0 on the previous cycle
module edge_rise (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/pause_gate.sv
// pause_gate: stops the CPU clock-enable at a safe point while a pause is requested.
//   clk_sys     in  core system clock
//   reset_n     in  asynchronous active-low reset
//   pause_req   in  pause request (active-high)
//   cen_in      in  CPU clock-enable pulse from the core divider
//   bus_idle    in  CPU not mid memory/IO cycle
//   vblank      in  vertical blank
//   cen_out     out gated CPU clock-enable (0 while reset_n is low)
//   paused      out registered acknowledge, high while the CPU is held
//   forced      out sticky: last hold entry came from the drain timeout
//   held_frames out vblank rising edges seen while held, saturating
module pause_gate
    import pause_pkg::*;
#(
    parameter int CLKSPD      = 12,
    parameter bit SYNC_VBLANK = 1'b1,
    parameter int DRAIN_MAX   = CLKSPD * 1000 * DRAIN_MS
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     pause_req,
    input  logic                     cen_in,
    input  logic                     bus_idle,
    input  logic                     vblank,
    output logic                     cen_out,
    output logic                     paused,
    output logic                     forced,
    output logic [HELD_FRAMES_W-1:0] held_frames
);

    // One spare bit so the counter can step past DRAIN_MAX-1 without wrapping.
    localparam int                CNT_W      = $clog2(DRAIN_MAX) + 1;
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);
    localparam logic [HELD_FRAMES_W-1:0] FRAMES_SAT = {HELD_FRAMES_W{1'b1}};

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] drain_cnt;
    logic             vb_rise;
    logic             safe;
    logic             timeout;
    logic             run_en;

    edge_rise u_vblank_rise (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .d       (vblank),
        .rise    (vb_rise)
    );

    assign safe    = bus_idle & ((SYNC_VBLANK == 1'b0) | vb_rise);
    assign timeout = (state == DRAIN) && (drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Cancel wins over safe, and safe wins over timeout.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (pause_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (!pause_req)          state_next = RUN;
                else if (safe | timeout) state_next = HELD;
            end
            HELD: begin
                if (!pause_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // In DRAIN the enable is cut on the decision cycle itself, so no pulse
    // slips through after the hold has been chosen.
    always_comb begin
        run_en = 1'b0;
        case (state)
            RUN:     run_en = 1'b1;
            DRAIN:   run_en = ~(safe | timeout);
            HELD:    run_en = 1'b0;
            default: run_en = 1'b0;
        endcase
    end

    assign cen_out = cen_in & run_en & reset_n;

    // held_frames is cleared on DRAIN entry so the final count survives resume.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            drain_cnt   <= '0;
            held_frames <= '0;
            forced      <= 1'b0;
            paused      <= 1'b0;
        end else begin
            paused <= (state_next == HELD);
            if (state == RUN && pause_req) begin
                drain_cnt   <= '0;
                held_frames <= '0;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
            if (state == DRAIN && state_next == HELD) begin
                forced <= ~safe;
            end
            if (state == HELD && vb_rise && held_frames != FRAMES_SAT) begin
                held_frames <= held_frames + 1'b1;
            end
        end
    end

endmodule

// File: doc/pause_gate.md
Name: pause_gate

Overview:
- CPU-side responder to the pause request produced by the core's pause controller.
- Takes a pause request and stops the CPU clock-enable only at a safe point: CPU bus idle and, optionally, the start of vertical blank.
- Holds the CPU while the request stays asserted, then resumes cleanly.
- Returns a registered acknowledge and a saturating count of frames held, for use by the video dimming and hiscore logic.

Parameters:
- CLKSPD, 12, main clock speed in MHz.
- SYNC_VBLANK, 1, when 1 the entry point must also coincide with a vblank rising edge.
- DRAIN_MAX, CLKSPD*20000, clk_sys cycles allowed in DRAIN before a forced hold (20 ms, just over one frame).

Ports:
- clk_sys  in  1  core system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- pause_req  in  1  pause request (active-high), synchronous to clk_sys.
- cen_in  in  1  CPU clock-enable pulse from the core divider.
- bus_idle  in  1  CPU not mid memory/IO cycle (active-high).
- vblank  in  1  vertical blank (active-high).
- cen_out  out  1  gated CPU clock-enable.
- paused  out  1  acknowledge: CPU is held (active-high).
- forced  out  1  sticky flag: the last entry was forced by timeout.
- held_frames  out  16  vblank rising edges counted while held, saturating.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=RUN, paused=0, forced=0, held_frames=0, drain counter=0, vblank_q=0.
  - cen_out is forced 0 combinationally while reset_n is low.
- Edge detection: vblank_q<=vblank; vb_rise = vblank & ~vblank_q.
- safe = bus_idle & (SYNC_VBLANK==0 | vb_rise).
- cen_out is combinational: cen_in & run_en.
  - RUN: run_en=1.
  - DRAIN: run_en=~(safe | timeout).
  - HELD: run_en=0.
- States:
  - RUN:
    - pause_req=1 -> DRAIN, drain counter cleared.
  - DRAIN:
    - Counter increments every cycle.
    - pause_req=0 -> RUN; cancel takes priority over safe on the same cycle.
    - Else safe=1 -> HELD, forced<=0.
    - Else counter==DRAIN_MAX-1 (timeout) -> HELD, forced<=1.
    - On the transition cycle, cen_in is already suppressed, so no pulse escapes after the decision.
  - HELD:
    - paused=1 (registered: high starting the first HELD cycle).
    - held_frames increments on each vb_rise and saturates at 16'hFFFF.
    - pause_req=0 -> RUN. cen_out may pass cen_in from the next cycle; paused drops in the same cycle.
- held_frames clears on entry to DRAIN, not on exit from HELD, so consumers can read the final count after resume.
- forced holds its value until the next HELD entry or reset.
- Boundary conditions:
  - pause_req pulsing for 1 cycle with safe=0: DRAIN then RUN, no hold, no cen pulse lost except in cycles where safe was true.
  - pause_req re-asserted in the cycle HELD exits: RUN for one cycle, then DRAIN again. There is no direct HELD->HELD path.
  - vb_rise and timeout in the same cycle: the entry counts as safe (forced=0).
  - Reset mid-DRAIN or mid-HELD: immediate return to RUN values. cen_out stays 0 until reset_n rises.
  - DRAIN counter width is $clog2(DRAIN_MAX)+1 and does not wrap; its value is ignored outside DRAIN.

Decomposition:
- Shared package pause_pkg:
  - State enum: RUN=2'd0, DRAIN=2'd1, HELD=2'd2.
  - DRAIN_MS default constant.
  - HELD_FRAMES_W=16.
- One sub-module is natural: edge_rise (1-bit registered rising-edge detector with async active-low reset). It is reused for vblank and is available to the pause controller's button logic.
- Everything else stays in pause_gate.

Test Plan:
- Reset release, pause_req=0, cen_in toggling every 4th cycle -> cen_out identical to cen_in; paused=0; held_frames=0.
- SYNC_VBLANK=1, bus_idle=1: pause_req=1 at cycle 10, vblank rises at cycle 50 -> cen_out 0 from cycle 50; paused=1 at cycle 51; forced=0.
- pause_req=1 with vblank stuck low, DRAIN_MAX=100 -> HELD entered on the 100th DRAIN cycle; forced=1; no cen_out pulses after that cycle.
- Held for 3 vblank rising edges, then pause_req=0 -> held_frames=3; paused=0 next cycle; cen_out follows cen_in again; held_frames still reads 3.
- pause_req asserted 1 cycle with bus_idle=0 -> returns to RUN after one DRAIN cycle; paused never asserts; cen_out uninterrupted.
- reset_n driven low during HELD -> paused=0 and cen_out=0 asynchronously; after release, state RUN, forced=0, held_frames=0.
